// File: rtl/alu72_if.sv
// alu72_if: operand/opcode/result bundle between the register-file read
// ports (master) and the ALU (slave).
//   op   [3:0]   operation select            master -> slave
//   A    [71:0]  operand A, unsigned         master -> slave
//   B    [71:0]  operand B / immediate       master -> slave
//   C    [71:0]  registered result           slave  -> master
//   done         C holds a valid result      slave  -> master
interface alu72_if;
    logic [3:0]  op;
    logic [71:0] A;
    logic [71:0] B;
    logic [71:0] C;
    logic        done;

    modport master (
        output op,
        output A,
        output B,
        input  C,
        input  done
    );

    modport slave (
        input  op,
        input  A,
        input  B,
        output C,
        output done
    );
endinterface

// File: rtl/alu72.sv
// alu72: 72-bit unsigned ALU with a single registered result stage.
// Ports:
//   clk    sole clock, rising-edge
//   rst_n  asynchronous active-low reset; clears C and done immediately
//   bus    alu72_if.slave: op/A/B in, C/done out
// All 16 operations (including MUL and DIV) resolve in one cycle; a new op
// is accepted on every edge. Arithmetic wraps modulo 2^72 with no flags.
module alu72 (
    input  logic    clk,
    input  logic    rst_n,
    alu72_if.slave  bus
);

    localparam int unsigned W     = 72;
    localparam int unsigned IMM_W = 18;
    localparam int unsigned SH_W  = 7;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_LSL  = 4'd4;
    localparam logic [3:0] OP_LSR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SUBI = 4'd7;
    localparam logic [3:0] OP_ANDI = 4'd8;
    localparam logic [3:0] OP_LAND = 4'd9;
    localparam logic [3:0] OP_LOR  = 4'd10;
    localparam logic [3:0] OP_XOR  = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_BNE  = 4'd13;
    localparam logic [3:0] OP_BLT  = 4'd14;
    localparam logic [3:0] OP_BGT  = 4'd15;

    logic [W-1:0]    r_c;
    logic            r_done;

    logic [W-1:0]    w_result;
    logic [W-1:0]    w_imm;
    logic [W-1:0]    w_mul;
    logic [W-1:0]    w_div;
    logic [W-1:0]    w_shl;
    logic [W-1:0]    w_shr;
    logic [SH_W-1:0] w_shamt;
    logic            w_sh_ovf;
    logic            w_b_zero;
    logic            w_a_nz;
    logic            w_b_nz;

    // Immediate ops only see the low 18 bits of B, zero-extended.
    assign w_imm = W'(bus.B[IMM_W-1:0]);

    assign w_a_nz   = |bus.A;
    assign w_b_nz   = |bus.B;
    assign w_b_zero = ~w_b_nz;

    // Low 72 bits of the product; upper half is discarded.
    assign w_mul = bus.A * bus.B;

    // Divide by zero returns all ones rather than an undefined quotient.
    assign w_div = w_b_zero ? {W{1'b1}} : (bus.A / bus.B);

    // Any shift amount >= 72 (including large upper bits of B) yields zero;
    // otherwise only the low 7 bits are meaningful.
    assign w_sh_ovf = (bus.B >= W'(W));
    assign w_shamt  = bus.B[SH_W-1:0];
    assign w_shl    = w_sh_ovf ? '0 : (bus.A << w_shamt);
    assign w_shr    = w_sh_ovf ? '0 : (bus.A >> w_shamt);

    // Result select.
    always_comb begin
        w_result = '0;
        case (bus.op)
            OP_ADD:  w_result = bus.A + bus.B;
            OP_SUB:  w_result = bus.A - bus.B;
            OP_MUL:  w_result = w_mul;
            OP_DIV:  w_result = w_div;
            OP_LSL:  w_result = w_shl;
            OP_LSR:  w_result = w_shr;
            OP_ADDI: w_result = bus.A + w_imm;
            OP_SUBI: w_result = bus.A - w_imm;
            OP_ANDI: w_result = bus.A & w_imm;
            OP_LAND: w_result = W'(w_a_nz & w_b_nz);
            OP_LOR:  w_result = W'(w_a_nz | w_b_nz);
            OP_XOR:  w_result = bus.A ^ bus.B;
            OP_BEQ:  w_result = W'(bus.A == bus.B);
            OP_BNE:  w_result = W'(bus.A != bus.B);
            OP_BLT:  w_result = W'(bus.A < bus.B);
            OP_BGT:  w_result = W'(bus.A > bus.B);
            default: w_result = '0;
        endcase
    end

    // Result register; done rises on the first edge after reset and stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c    <= '0;
            r_done <= 1'b0;
        end else begin
            r_c    <= w_result;
            r_done <= 1'b1;
        end
    end

    assign bus.C    = r_c;
    assign bus.done = r_done;

endmodule

// File: tb/tb_alu72.sv
// tb_alu72: directed vectors for alu72. The driver pushes each hand-computed
// expected result into a queue when it presents the op; an independent
// monitor pops and compares one result per edge while the queue is non-empty.
module tb_alu72;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu72_if bus ();

    alu72 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [71:0] ONES  = {72{1'b1}};
    localparam logic [71:0] TOP   = 72'h80_0000_0000_0000_0000;

    logic [71:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one op at the falling edge and record its expected result.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [71:0] a, input logic [71:0] b,
                         input logic [71:0] exp);
        @(negedge clk);
        bus.op = op;
        bus.A  = a;
        bus.B  = b;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Monitor: the result of an op presented before an edge is visible just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            string       n;
            logic [71:0] e;
            n = name_q.pop_front();
            e = exp_q.pop_front();
            check({n, "_done"}, 72'(bus.done), 72'd1);
            check(n, bus.C, e);
        end
    end

    initial begin
        rst_n  = 1'b0;
        bus.op = 4'd0;
        bus.A  = 72'd5;
        bus.B  = 72'd3;

        // Clocks running under reset must not load anything.
        repeat (3) @(posedge clk);
        #1;
        check("rst_c", bus.C, 72'd0);
        check("rst_done", 72'(bus.done), 72'd0);

        // Release with ADD 5+3 already on the inputs.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(72'd8);
        name_q.push_back("rst_release_add");

        issue("add",        4'd0,  72'd10,  72'd15, 72'd25);
        issue("sub",        4'd1,  72'd50,  72'd20, 72'd30);
        issue("mul",        4'd2,  72'd6,   72'd7,  72'd42);
        issue("div",        4'd3,  72'd100, 72'd5,  72'd20);
        issue("sub_wrap",   4'd1,  72'd0,   72'd1,  ONES);
        issue("div_zero",   4'd3,  72'd7,   72'd0,  ONES);
        issue("div_floor",  4'd3,  72'd7,   72'd2,  72'd3);
        issue("add_wrap",   4'd0,  ONES,    72'd1,  72'd0);
        issue("mul_wrap",   4'd2,  TOP,     72'd2,  72'd0);
        issue("lsl",        4'd4,  72'd1,   72'd2,  72'd4);
        issue("lsr",        4'd5,  72'd16,  72'd1,  72'd8);
        issue("lsl_72",     4'd4,  72'd1,   72'd72, 72'd0);
        issue("lsl_71",     4'd4,  72'd1,   72'd71, TOP);
        issue("lsr_72",     4'd5,  ONES,    72'd72, 72'd0);
        issue("lsl_huge",   4'd4,  72'd1,   72'h100_0000_0002, 72'd0);
        issue("addi",       4'd6,  72'd100, 72'd5,  72'd105);
        issue("subi",       4'd7,  72'd100, 72'd20, 72'd80);
        issue("andi",       4'd8,  72'd15,  72'd10, 72'd10);
        issue("addi_trunc", 4'd6,  72'd0,   72'h4_0003, 72'd3);
        issue("subi_wrap",  4'd7,  72'd0,   72'h4_0001, ONES);
        issue("andi_trunc", 4'd8,  ONES,    ONES,   72'h3_FFFF);
        issue("land_10",    4'd9,  72'd1,   72'd0,  72'd0);
        issue("lor_01",     4'd10, 72'd0,   72'd1,  72'd1);
        issue("lor_00",     4'd10, 72'd0,   72'd0,  72'd0);
        issue("xor",        4'd11, 72'd3,   72'd1,  72'd2);
        issue("land_top",   4'd9,  TOP,     72'd5,  72'd1);
        issue("beq",        4'd12, 72'd50,  72'd50, 72'd1);
        issue("beq_ne",     4'd12, 72'd50,  72'd40, 72'd0);
        issue("bne",        4'd13, 72'd50,  72'd40, 72'd1);
        issue("blt",        4'd14, 72'd30,  72'd40, 72'd1);
        issue("bgt",        4'd15, 72'd70,  72'd60, 72'd1);
        issue("bgt_false",  4'd15, 72'd60,  72'd70, 72'd0);
        issue("blt_equal",  4'd14, 72'd40,  72'd40, 72'd0);
        issue("blt_top",    4'd14, 72'd1,   TOP,    72'd1);

        // Back-to-back ops, each result one edge after it was presented.
        issue("pipe_add",   4'd0,  72'd2,   72'd3,  72'd5);
        issue("pipe_mul",   4'd2,  72'd4,   72'd9,  72'd36);
        issue("pipe_beq",   4'd12, 72'd8,   72'd8,  72'd1);
        drain();

        // Inputs changed after the edge must not disturb the held result.
        issue("hold_xor",   4'd11, 72'hF0,  72'h0F, 72'hFF);
        drain();
        #1;
        bus.op = 4'd0;
        bus.A  = 72'd1000;
        bus.B  = 72'd1;
        @(negedge clk);
        check("hold_between_edges", bus.C, 72'hFF);

        // Asynchronous reset between edges drops the held result at once.
        @(posedge clk);
        #2;
        check("pre_rst_c", bus.C, 72'd1001);
        rst_n = 1'b0;
        #1;
        check("async_rst_c", bus.C, 72'd0);
        check("async_rst_done", 72'(bus.done), 72'd0);
        @(posedge clk);
        #1;
        check("rst_hold_c", bus.C, 72'd0);
        check("rst_hold_done", 72'(bus.done), 72'd0);

        // Recovery after the second reset.
        @(negedge clk);
        rst_n = 1'b1;
        bus.op = 4'd13;
        bus.A  = 72'd9;
        bus.B  = 72'd9;
        exp_q.push_back(72'd0);
        name_q.push_back("post_rst_bne");
        issue("post_rst_sub", 4'd1, 72'd9, 72'd4, 72'd5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
